// File: rtl/complex_addsub_pipe_if.sv
// Operand/result handshake bundle for complex_addsub_pipe.
interface complex_addsub_pipe_if #(
  parameter int unsigned W = 11
);
  logic           in_valid;
  logic           in_ready;
  logic           op;
  logic [2*W-1:0] A;
  logic [2*W-1:0] B;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] Y;
  logic           ovf;

  // Producer/consumer side (testbench or surrounding datapath)
  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, Y, ovf
  );

  // Block side
  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, Y, ovf
  );
endinterface

// File: rtl/complex_addsub_pipe.sv
// Two-stage pipelined complex adder/subtractor with valid/ready backpressure,
// optional 1/2 scaling with round-half-up, and overflow tracking.
// Build option: define CPLX_ADDSUB_SAT_EN to saturate overflowed components
// instead of wrapping them.
module complex_addsub_pipe #(
  parameter int unsigned W     = 11,
  parameter int unsigned SCALE = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  complex_addsub_pipe_if.slave  bus,
  input  logic                  ovf_clr,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      ovf_cnt
);

  localparam int unsigned SW = W + 1;

  logic          s1_adv, s2_adv, out_fire, ovf_evt;
  logic [SW-1:0] op_ar, op_ai, op_br, op_bi;
  logic [W:0]    red_r, red_i;

  logic          s1_valid_q, s1_valid_d;
  logic [SW-1:0] s1_sr_q, s1_sr_d, s1_si_q, s1_si_d;
  logic          s2_valid_q, s2_valid_d;
  logic [2*W-1:0] y_q, y_d;
  logic          ovf_q, ovf_d;
  logic          sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [SW-1:0] sext(input logic [W-1:0] x);
    return {x[W-1], x};
  endfunction

  // Map a W+1-bit sum to {ovf, W-bit result}
  function automatic logic [W:0] reduce(input logic [SW-1:0] s);
    logic [SW:0]  r;
    logic [W-1:0] y;
    logic         o;
    r = '0;
    if (SCALE != 0) begin
      r = {s[SW-1], s} + (SW+1)'(1);
      y = W'(r >> 1);
      o = 1'b0;
    end else begin
      o = s[W] ^ s[W-1];
`ifdef CPLX_ADDSUB_SAT_EN
      if (o) y = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else   y = s[W-1:0];
`else
      y = s[W-1:0];
`endif
    end
    return {o, y};
  endfunction

  // Handshake: in_ready/out_valid forced to their reset values while rst is high
  always_comb begin
    s2_adv        = !s2_valid_q || bus.out_ready;
    s1_adv        = !s1_valid_q || s2_adv;
    bus.in_ready  = s1_adv || rst;
    bus.out_valid = s2_valid_q && !rst;
    out_fire      = bus.out_valid && bus.out_ready;
    ovf_evt       = out_fire && ovf_q;
  end

  // Sign-extend operand components
  always_comb begin
    op_ar = sext(bus.A[2*W-1:W]);
    op_ai = sext(bus.A[W-1:0]);
    op_br = sext(bus.B[2*W-1:W]);
    op_bi = sext(bus.B[W-1:0]);
  end

  // Stage 1: full-precision add/subtract
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sr_d    = s1_sr_q;
    s1_si_d    = s1_si_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sr_d = bus.op ? (op_ar - op_br) : (op_ar + op_br);
        s1_si_d = bus.op ? (op_ai - op_bi) : (op_ai + op_bi);
      end
    end
  end

  // Stage 2: narrow to W bits and flag overflow
  always_comb begin
    red_r      = reduce(s1_sr_q);
    red_i      = reduce(s1_si_q);
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    ovf_d      = ovf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d   = {red_r[W-1:0], red_i[W-1:0]};
        ovf_d = red_r[W] | red_i[W];
      end
    end
  end

  // Overflow bookkeeping on delivered samples; an event beats a clear
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (ovf_evt) begin
      sticky_d = 1'b1;
      if (ovf_clr)          cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stage-1 datapath registers, qualified by s1_valid_q
  always_ff @(posedge clk) begin
    s1_sr_q <= s1_sr_d;
    s1_si_q <= s1_si_d;
  end

  assign bus.Y      = y_q;
  assign bus.ovf    = ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Randomized and directed bench for complex_addsub_pipe against a queue-based model.
module tb_complex_addsub_pipe;
  localparam int unsigned W     = 11;
  localparam int unsigned CNT_W = 16;
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));
  localparam longint MAXC = (longint'(1) << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  complex_addsub_pipe_if #(.W(W)) bus ();
  complex_addsub_pipe_if #(.W(W)) bus_s ();

  logic             ovf_clr = 1'b0;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_cnt;
  logic             s_clr = 1'b0;
  logic             s_sticky;
  logic [CNT_W-1:0] s_cnt;

  complex_addsub_pipe #(.W(W), .SCALE(0), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt)
  );

  complex_addsub_pipe #(.W(W), .SCALE(1), .CNT_W(CNT_W)) u_dut_scaled (
    .clk(clk), .rst(rst), .bus(bus_s),
    .ovf_clr(s_clr), .ovf_sticky(s_sticky), .ovf_cnt(s_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit bp_mode = 1'b0;

  typedef struct {
    logic [2*W-1:0] y;
    bit             ovf;
    longint         acc;
  } exp_t;

  exp_t   q[$];
  exp_t   head, ent;
  longint cyc = 0;
  bit     m_sticky = 1'b0;
  longint m_cnt = 0;
  bit     exp_ready, exp_valid, evt;

  function automatic logic [2*W-1:0] pk(input int r, input int i);
    return {W'(r), W'(i)};
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // One component of the result from the arithmetic rules
  function automatic int comp(input int s, input bit scale, output bit o);
    o = 1'b0;
    if (scale) return (s + 1) >>> 1;
    if (s > MAXV) begin
      o = 1'b1;
`ifdef CPLX_ADDSUB_SAT_EN
      return MAXV;
`else
      return s - (1 << W);
`endif
    end
    if (s < MINV) begin
      o = 1'b1;
`ifdef CPLX_ADDSUB_SAT_EN
      return MINV;
`else
      return s + (1 << W);
`endif
    end
    return s;
  endfunction

  function automatic void ref_calc(input int ar, input int ai, input int br, input int bi,
                                   input bit op, input bit scale,
                                   output logic [2*W-1:0] y, output bit o);
    int sr, si, yr, yi;
    bit orr, oi;
    sr = op ? ar - br : ar + br;
    si = op ? ai - bi : ai + bi;
    yr = comp(sr, scale, orr);
    yi = comp(si, scale, oi);
    y  = pk(yr, yi);
    o  = orr | oi;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi, input bit op);
    bus.A = pk(ar, ai);
    bus.B = pk(br, bi);
    bus.op = op;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (bus.in_ready) begin
        step();
        bus.in_valid = 1'b0;
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
    bus.in_valid = 1'b0;
  endtask

  // Compare process: checks every cycle, then advances the model to the next edge
  always @(negedge clk) begin
    exp_ready = !(q.size() == 2 && !bus.out_ready);
    exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
    if (cyc > 0) begin
      chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
      chk("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt[CNT_W-1:0]));
      if (rst) begin
        chk("out_valid_in_rst", 64'(bus.out_valid), 64'd0);
        chk("in_ready_in_rst", 64'(bus.in_ready), 64'd1);
      end else begin
        chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        if (exp_valid) begin
          chk("Y", 64'(bus.Y), 64'(q[0].y));
          chk("ovf", 64'(bus.ovf), 64'(q[0].ovf));
        end
      end
    end
    if (rst) begin
      q.delete();
      m_sticky = 1'b0;
      m_cnt = 0;
    end else begin
      evt = 1'b0;
      if (exp_valid && bus.out_ready) begin
        head = q.pop_front();
        evt  = head.ovf;
      end
      if (evt) begin
        m_sticky = 1'b1;
        m_cnt = ovf_clr ? 1 : ((m_cnt == MAXC) ? MAXC : m_cnt + 1);
      end else if (ovf_clr) begin
        m_sticky = 1'b0;
        m_cnt = 0;
      end
      if (bus.in_valid && exp_ready) begin
        ref_calc(sx(bus.A[2*W-1:W]), sx(bus.A[W-1:0]), sx(bus.B[2*W-1:W]), sx(bus.B[W-1:0]),
                 bus.op, 1'b0, ent.y, ent.ovf);
        ent.acc = cyc;
        q.push_back(ent);
      end
    end
    cyc++;
  end

  logic [2*W-1:0] ym;
  bit             om;
  int             n_wait;

  initial begin
    bus.in_valid = 1'b0; bus.op = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.op = 1'b0; bus_s.A = '0; bus_s.B = '0; bus_s.out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_Y", 64'(bus.Y), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_cnt", 64'(ovf_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    step();

    // Plain add, 2-cycle latency
    ref_calc(100, -50, 20, 30, 1'b0, 1'b0, ym, om);
    chk("model_add", 64'(ym), 64'(pk(120, -20)));
    send(100, -50, 20, 30, 1'b0);
    chk("t1_not_yet", 64'(bus.out_valid), 64'd0);
    step();
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_Y", 64'(bus.Y), 64'(pk(120, -20)));
    chk("t1_ovf", 64'(bus.ovf), 64'd0);

    // Overflowing subtract
    send(1000, 5, -100, 5, 1'b1);
    step();
`ifdef CPLX_ADDSUB_SAT_EN
    chk("t2_Y", 64'(bus.Y), 64'(pk(1023, 0)));
`else
    chk("t2_Y", 64'(bus.Y), 64'(pk(-948, 0)));
`endif
    chk("t2_ovf", 64'(bus.ovf), 64'd1);
    step();
    chk("t2_sticky", 64'(ovf_sticky), 64'd1);
    chk("t2_cnt", 64'(ovf_cnt), 64'd1);

    // Back-to-back with 3 cycles of backpressure
    send(1, 2, 3, 4, 1'b0);
    send(10, 20, 5, 5, 1'b1);
    bus.out_ready = 1'b0;
    bus.A = pk(-7, 8); bus.B = pk(-1, -2); bus.op = 1'b0; bus.in_valid = 1'b1;
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_hold_Y", 64'(bus.Y), 64'(pk(4, 6)));
    repeat (3) begin
      step();
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_Y", 64'(bus.Y), 64'(pk(4, 6)));
    end
    bus.out_ready = 1'b1;
    send(-7, 8, -1, -2, 1'b0);
    send(300, -300, -400, 400, 1'b1);
    repeat (4) step();

    // Randomized traffic with random backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(sx(W'($urandom)), sx(W'($urandom)), sx(W'($urandom)), sx(W'($urandom)),
           1'($urandom_range(0, 1)));
    end
    bp_mode = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Clear, count to 5, then clear in the same cycle as a counted event
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_sticky", 64'(ovf_sticky), 64'd0);
    chk("clr_cnt", 64'(ovf_cnt), 64'd0);
    repeat (5) send(1000, 0, -100, 0, 1'b1);
    repeat (3) step();
    chk("cnt5", 64'(ovf_cnt), 64'd5);
    send(1000, 0, -100, 0, 1'b1);
    n_wait = 0;
    while (!bus.out_valid && n_wait < 10) begin
      step();
      n_wait++;
    end
    chk("clr_evt_wait", 64'(bus.out_valid), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_evt_sticky", 64'(ovf_sticky), 64'd1);
    chk("clr_evt_cnt", 64'(ovf_cnt), 64'd1);

    // Reset with both stages full and stalled
    bus.out_ready = 1'b0;
    send(1000, 0, -100, 0, 1'b1);
    send(2, 2, 1, 1, 1'b0);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_cnt", 64'(ovf_cnt), 64'd0);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    send(-5, 9, 6, -4, 1'b0);
    chk("post_rst_lat1", 64'(bus.out_valid), 64'd0);
    step();
    chk("post_rst_lat2", 64'(bus.out_valid), 64'd1);
    chk("post_rst_Y", 64'(bus.Y), 64'(pk(1, 5)));
    step();

    // Scaled instance: round-half-up halving never overflows
    ref_calc(3, -3, 0, 0, 1'b0, 1'b1, ym, om);
    chk("model_scale", 64'(ym), 64'(pk(2, -1)));
    bus_s.A = pk(1023, -1024); bus_s.B = pk(1023, -1024); bus_s.op = 1'b0; bus_s.in_valid = 1'b1;
    step();
    bus_s.A = pk(3, -3); bus_s.B = pk(0, 0);
    step();
    bus_s.in_valid = 1'b0;
    chk("sc1_valid", 64'(bus_s.out_valid), 64'd1);
    chk("sc1_Y", 64'(bus_s.Y), 64'(pk(1023, -1024)));
    chk("sc1_ovf", 64'(bus_s.ovf), 64'd0);
    step();
    chk("sc2_valid", 64'(bus_s.out_valid), 64'd1);
    chk("sc2_Y", 64'(bus_s.Y), 64'(pk(2, -1)));
    chk("sc2_ovf", 64'(bus_s.ovf), 64'd0);
    step();
    chk("sc_drained", 64'(bus_s.out_valid), 64'd0);

    // Counter saturation with a continuous overflow stream
    bus.A = pk(1000, 0); bus.B = pk(-100, 0); bus.op = 1'b1; bus.in_valid = 1'b1;
    repeat (65540) step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("cnt_sat", 64'(ovf_cnt), 64'hFFFF);
    chk("sat_sticky", 64'(ovf_sticky), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
